// File: rtl/multi_buffer.sv
// multi_buffer: parametrised multi-entry FIFO driven by edge-strobed push/pop.
//
// A rising edge on in_strobe pushes in_data; a rising edge on out_strobe pops
// the head word. Push and pop may occur together. The fill count is held in
// its own register. Overflow and underflow are sticky error flags. clear is a
// synchronous flush that takes priority over every strobe event.
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous active-low reset
//   in_data     word to push (sampled on the push edge cycle)
//   in_strobe   push request, rising-edge sensitive
//   out_data    head word, asynchronous read (don't-care while empty)
//   out_strobe  pop request, rising-edge sensitive
//   full        count == DEPTH
//   empty       count == 0
//   count       number of stored words, 0..DEPTH
//   overflow    sticky: push attempted while full with no concurrent pop
//   underflow   sticky: pop attempted while empty
//   clear       synchronous flush, level-sensitive
module multi_buffer #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_strobe,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_strobe,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  in_strobe_prev;
  logic                  out_strobe_prev;
  logic                  push_edge;
  logic                  pop_edge;
  logic                  do_push;
  logic                  do_pop;

  // Previous-value registers reset to 1 so a strobe held high through reset
  // does not register as an edge.
  assign push_edge = in_strobe  & ~in_strobe_prev;
  assign pop_edge  = out_strobe & ~out_strobe_prev;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A push into a full FIFO still proceeds when a pop frees the head slot in
  // the same cycle. A pop on an empty FIFO never proceeds, even alongside a
  // push, because the pushed word is not yet the head.
  assign do_push = push_edge & (~full | pop_edge);
  assign do_pop  = pop_edge  & ~empty;

  assign out_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and flags are initialised.
  always_ff @(posedge clk) begin
    if (!clear && do_push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_strobe_prev  <= 1'b1;
      out_strobe_prev <= 1'b1;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      // Edge registers track their inputs even while clear discards events.
      in_strobe_prev  <= in_strobe;
      out_strobe_prev <= out_strobe;
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (push_edge && full && !pop_edge) begin
          overflow <= 1'b1;
        end
        if (pop_edge && empty) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_buffer.sv
// tb_multi_buffer: directed bench for multi_buffer with a data scoreboard.
// The stimulus process keeps a reference queue of stored words; every pop it
// issues pushes the expected head word into exp_q. A separate monitor compares
// out_data against exp_q whenever the DUT takes a pop. Status outputs are
// compared against hand-computed values after each operation.
module tb_multi_buffer;

  localparam int WIDTH      = 8;
  localparam int ADDR_WIDTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [WIDTH-1:0]    in_data;
  logic                in_strobe;
  logic [WIDTH-1:0]    out_data;
  logic                out_strobe;
  logic                full;
  logic                empty;
  logic [ADDR_WIDTH:0] count;
  logic                overflow;
  logic                underflow;
  logic                clear;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q   [$];
  logic             out_prev_tb;

  multi_buffer #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear      (clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a pop edge is present in the half-cycle before the posedge that
  // commits it; out_data there is the word being removed.
  always @(posedge clk or negedge reset) begin
    if (!reset) out_prev_tb <= 1'b1;
    else        out_prev_tb <= out_strobe;
  end

  always @(negedge clk) begin
    if (reset && !clear && out_strobe && !out_prev_tb && !empty) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no pop data", out_data);
      end else begin
        chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    in_data   = v;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    tick();
    if (model_q.size() < 16) model_q.push_back(v);
  endtask

  task automatic pop();
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    tick();
  endtask

  task automatic push_pop(input logic [WIDTH-1:0] v);
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    model_q.push_back(v);
    in_data    = v;
    in_strobe  = 1'b1;
    out_strobe = 1'b1;
    tick();
    in_strobe  = 1'b0;
    out_strobe = 1'b0;
    tick();
  endtask

  task automatic status(input string tag, input int c, input logic f, input logic e,
                        input logic ov, input logic un);
    chk({tag, "_count"},     32'(count),     32'(c));
    chk({tag, "_full"},      32'(full),      32'(f));
    chk({tag, "_empty"},     32'(empty),     32'(e));
    chk({tag, "_overflow"},  32'(overflow),  32'(ov));
    chk({tag, "_underflow"}, 32'(underflow), 32'(un));
  endtask

  initial begin
    reset      = 1'b0;
    in_data    = '0;
    in_strobe  = 1'b1;   // held high through reset release
    out_strobe = 1'b0;
    clear      = 1'b0;
    tick();
    tick();
    status("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    status("strobe_held", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    in_strobe = 1'b0;
    tick();

    // Fill and overflow
    for (int i = 0; i < 16; i++) push(8'(i));
    status("filled", 16, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'hAA);
    status("overflow", 16, 1'b1, 1'b0, 1'b1, 1'b0);

    // Drain, then underflow on empty
    for (int i = 0; i < 16; i++) pop();
    status("drained", 0, 1'b0, 1'b1, 1'b1, 1'b0);
    pop();
    status("underflow", 0, 1'b0, 1'b1, 1'b1, 1'b1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    status("clear1", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Simultaneous push/pop at full
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push_pop(8'h55);
    status("pp_full", 16, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) pop();
    status("pp_drain", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Simultaneous push/pop at empty: push taken, pop refused
    in_data    = 8'h11;
    in_strobe  = 1'b1;
    out_strobe = 1'b1;
    tick();
    in_strobe  = 1'b0;
    out_strobe = 1'b0;
    tick();
    model_q.push_back(8'h11);
    status("pp_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pp_empty_data", 32'(out_data), 32'h11);
    pop();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_q.delete();

    // Wrap-around at a standing depth of 3
    for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
    for (int i = 0; i < 40; i++) push_pop(8'(8'h83 + i));
    status("wrap", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pop();

    // Clear at count 7 with a concurrent push edge
    for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
    chk("pre_clear_count", 32'(count), 32'd7);
    in_data   = 8'hEE;
    in_strobe = 1'b1;
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
    in_strobe = 1'b0;
    model_q.delete();
    status("clear_push", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    push(8'h77);
    chk("after_clear_head", 32'(out_data), 32'h77);
    chk("after_clear_count", 32'(count), 32'd1);
    pop();

    // Reset mid-stream discards contents
    push(8'h31);
    push(8'h32);
    #2 reset = 1'b0;
    #2;
    status("async_reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    model_q.delete();
    tick();
    push(8'h99);
    chk("post_reset_head", 32'(out_data), 32'h99);
    pop();
    status("final", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
